operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 Parameter CTRL_W, default 8, width of the opaque decoded-control bundle carried alongside the operands.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 in_valid / in_ready  input / output  1 / 1  decode-side handshake; a transfer occurs when both are 1 at a rising edge.
REQ-005 in_rs1, in_rs2, in_rd  input  5 each  source and destination register addresses.
REQ-006 in_imm / in_ctrl  input  32 / CTRL_W  immediate and control bundle, carried unmodified.
REQ-007 rf_raddr1, rf_raddr2  output  5 each  register-file read addresses, driven combinationally equal to in_rs1 and in_rs2.
REQ-008 rf_rdata1, rf_rdata2  input  32 each  asynchronous register-file read data for rf_raddr1 and rf_raddr2.
REQ-009 wb_en, wb_rd, wb_data  input  1/5/32  writeback port, same values that drive the register-file write.
REQ-010 flush  input  1  synchronous discard of all held entries.
REQ-011 out_valid / out_ready  output / input  1 / 1  execute-side handshake; a transfer occurs when both are 1 at a rising edge.
REQ-012 out_op1, out_op2, out_imm, out_rd, out_ctrl  output  32/32/32/5/CTRL_W  payload of the head entry.

Function
REQ-013 The block SHALL hold up to two entries, main and skid, and SHALL use states EMPTY (none), ONE (main only), and TWO (main and skid).
REQ-014 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO and while reset is asserted; it SHALL be a function of state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL be 1 in ONE and TWO, and all out_* payload SHALL be driven from the main entry only.
REQ-016 EMPTY: on an input transfer, the state SHALL go to ONE and load main; otherwise it SHALL stay EMPTY.
REQ-017 ONE, output and input transfer together: main SHALL be reloaded with the new input and the state SHALL stay ONE.
REQ-018 ONE, output transfer only: the state SHALL go to EMPTY.
REQ-019 ONE, input transfer only: skid SHALL be loaded and the state SHALL go to TWO.
REQ-020 ONE, neither transfer: main SHALL be held and the state SHALL stay ONE.
REQ-021 TWO, output transfer: skid SHALL move to main and the state SHALL go to ONE; otherwise both entries SHALL be held.
REQ-022 Latency from an input transfer into EMPTY to out_valid=1 SHALL be exactly one cycle, and entries SHALL leave in strict acceptance order.
REQ-023 flush SHALL take priority over every other event: the next state SHALL be EMPTY, and any input or output transfer in the flush cycle SHALL be discarded.
REQ-024 An operand whose source address is 0 SHALL be captured as 32'h0 regardless of rf_rdata or writeback.
REQ-025 Each entry SHALL store rs1 and rs2 alongside its operands for use by the bypass logic in REQ-027.

Reset
REQ-026 While reset is asserted, asynchronously: state SHALL be EMPTY; out_valid SHALL be 0; in_ready SHALL be 0; all stored payload, rs fields, out_op1, out_op2, out_imm, out_rd, and out_ctrl SHALL be 0; in_ready SHALL be 1 from the first cycle after release.

Configuration
REQ-027 Macro WB_BYPASS_EN, when defined, SHALL enable writeback bypass.
- At capture, if wb_en=1, wb_rd!=0 and wb_rd equals rs1 or rs2, that operand SHALL take wb_data instead of rf_rdata.
- Every cycle, any held entry whose stored rs1 or rs2 equals a nonzero wb_rd with wb_en=1 SHALL have that operand overwritten with wb_data.
REQ-028 When WB_BYPASS_EN is undefined:
- Operands SHALL be captured from rf_rdata1 and rf_rdata2 only, with the x0 rule of REQ-024 still applied.
- Held entries SHALL never be modified.
- All bypass logic SHALL be absent from the netlist.

Verification
REQ-029 Reset mid-stream while in TWO -> out_valid=0 and in_ready=0 immediately; after release, in_ready=1 and out_op1=0.
REQ-030 Hold out_ready=0 and push two entries (rd=3, then rd=4) -> in_ready=0 after the second transfer; raise out_ready -> out_rd=3, then out_rd=4 on consecutive cycles.
REQ-031 Push rs1=5 with rf_rdata1=32'h11111111 while wb_en=1, wb_rd=5, wb_data=32'hABCDEF12 -> out_op1=32'hABCDEF12 with WB_BYPASS_EN defined, and 32'h11111111 without it.
REQ-032 Stall an entry with rs2=7, then write back wb_rd=7, wb_data=32'h0000CAFE -> out_op2=32'h0000CAFE with WB_BYPASS_EN defined, and unchanged without it.
REQ-033 Push rs1=0 with rf_rdata1=32'hFFFFFFFF and wb_en=1, wb_rd=0 -> out_op1=32'h0.
REQ-034 Assert flush in TWO together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears at the output.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads register-file operands at capture and holds them in a two-entry main/skid buffer.
// Define WB_BYPASS_EN to forward writeback data into captured and held operands.
module operand_fetch_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [31:0]       in_imm,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_op1,
    output logic [31:0]       out_op2,
    output logic [31:0]       out_imm,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} stateType;

    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [31:0]       op1;
        logic [31:0]       op2;
        logic [31:0]       imm;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } entryType;

    stateType state, nextState;
    entryType mainQ, skidQ, mainD, skidD;
    entryType newEntry, mainHeld, skidHeld;
    logic     inFire, outFire;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;

`ifdef WB_BYPASS_EN
    function automatic logic [31:0] captureOperand(input logic [4:0] rs, input logic [31:0] rdata,
                                                   input logic en, input logic [4:0] rd,
                                                   input logic [31:0] data);
        if (rs == 5'd0)
            return 32'h0;
        else if (en && rd == rs)
            return data;
        else
            return rdata;
    endfunction

    // A nonzero rs matching the writeback register picks up the freshly written value.
    function automatic entryType refreshEntry(input entryType e, input logic en,
                                              input logic [4:0] rd, input logic [31:0] data);
        entryType r;
        r = e;
        if (en && rd != 5'd0) begin
            if (e.rs1 == rd) r.op1 = data;
            if (e.rs2 == rd) r.op2 = data;
        end
        return r;
    endfunction

    always_comb begin
        newEntry      = '0;
        newEntry.rs1  = in_rs1;
        newEntry.rs2  = in_rs2;
        newEntry.op1  = captureOperand(in_rs1, rf_rdata1, wb_en, wb_rd, wb_data);
        newEntry.op2  = captureOperand(in_rs2, rf_rdata2, wb_en, wb_rd, wb_data);
        newEntry.imm  = in_imm;
        newEntry.rd   = in_rd;
        newEntry.ctrl = in_ctrl;
    end

    assign mainHeld = refreshEntry(mainQ, wb_en, wb_rd, wb_data);
    assign skidHeld = refreshEntry(skidQ, wb_en, wb_rd, wb_data);
`else
    // Writeback port is intentionally ignored in this build.
    logic unusedWb;
    assign unusedWb = ^{wb_en, wb_rd, wb_data};

    always_comb begin
        newEntry      = '0;
        newEntry.rs1  = in_rs1;
        newEntry.rs2  = in_rs2;
        newEntry.op1  = (in_rs1 == 5'd0) ? 32'h0 : rf_rdata1;
        newEntry.op2  = (in_rs2 == 5'd0) ? 32'h0 : rf_rdata2;
        newEntry.imm  = in_imm;
        newEntry.rd   = in_rd;
        newEntry.ctrl = in_ctrl;
    end

    assign mainHeld = mainQ;
    assign skidHeld = skidQ;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            state <= nextState;
            mainQ <= mainD;
            skidQ <= skidD;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        nextState = state;
        mainD     = mainHeld;
        skidD     = skidHeld;
        unique case (state)
            EMPTY: begin
                if (inFire) begin
                    nextState = ONE;
                    mainD     = newEntry;
                end
            end
            ONE: begin
                if (outFire && inFire) begin
                    mainD = newEntry;
                end else if (outFire) begin
                    nextState = EMPTY;
                end else if (inFire) begin
                    nextState = TWO;
                    skidD     = newEntry;
                end
            end
            TWO: begin
                if (outFire) begin
                    nextState = ONE;
                    mainD     = skidHeld;
                end
            end
            default: nextState = EMPTY;
        endcase
        // Flush discards whatever the handshakes did this cycle.
        if (flush) begin
            nextState = EMPTY;
            mainD     = '0;
            skidD     = '0;
        end
    end

    always_comb begin
        in_ready  = !reset && (state != TWO);
        out_valid = (state != EMPTY);
        out_op1   = mainQ.op1;
        out_op2   = mainQ.op2;
        out_imm   = mainQ.imm;
        out_rd    = mainQ.rd;
        out_ctrl  = mainQ.ctrl;
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow WB_BYPASS_EN when it is defined.
module tb_operand_fetch_stage;

    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, in_ready;
    logic [4:0]        in_rs1, in_rs2, in_rd;
    logic [31:0]       in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        rf_raddr1, rf_raddr2;
    logic [31:0]       rf_rdata1, rf_rdata2;
    logic              wb_en;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              flush;
    logic              out_valid, out_ready;
    logic [31:0]       out_op1, out_op2, out_imm;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    int passCount = 0;
    int totalCount = 0;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] EXP_CAPTURE = 32'hABCDEF12;
    localparam logic [31:0] EXP_HELD    = 32'h0000CAFE;
`else
    localparam logic [31:0] EXP_CAPTURE = 32'h11111111;
    localparam logic [31:0] EXP_HELD    = 32'h77777777;
`endif

    operand_fetch_stage #(.CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_ctrl(in_ctrl),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rd(out_rd), .out_ctrl(out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        in_valid = 1'b1;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = {27'd0, rd};
        in_ctrl  = {3'd0, rd};
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_ctrl = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_op1", out_op1, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_ctrl", out_ctrl, 0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Capture-time bypass of rs1.
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd2; in_rd = 5'd1;
        in_imm = 32'h00001234; in_ctrl = 8'h5A;
        rf_rdata1 = 32'h11111111; rf_rdata2 = 32'h22222222;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hABCDEF12;
        #1;
        check("raddr1", rf_raddr1, 5);
        check("raddr2", rf_raddr2, 2);
        step();
        in_valid = 1'b0; wb_en = 1'b0;
        check("cap_out_valid", out_valid, 1);
        check("cap_op1", out_op1, EXP_CAPTURE);
        check("cap_op2", out_op2, 32'h22222222);
        check("cap_imm", out_imm, 32'h00001234);
        check("cap_rd", out_rd, 1);
        check("cap_ctrl", out_ctrl, 8'h5A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_out_valid", out_valid, 0);
        check("pop_in_ready", in_ready, 1);

        // x0 source reads as zero even with a writeback to x0.
        rf_rdata1 = 32'hFFFFFFFF; rf_rdata2 = 32'h33333333;
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        push(5'd2, 5'd0, 5'd3);
        wb_en = 1'b0;
        check("x0_op1", out_op1, 0);
        check("x0_op2", out_op2, 32'h33333333);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Held-entry refresh from writeback on rs2.
        rf_rdata1 = 32'h00000066; rf_rdata2 = 32'h77777777;
        push(5'd6, 5'd6, 5'd7);
        check("held_op2_before", out_op2, 32'h77777777);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000CAFE;
        step();
        wb_en = 1'b0;
        check("held_op2_after", out_op2, EXP_HELD);
        check("held_op1_kept", out_op1, 32'h00000066);
        check("held_out_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Fill both entries, stall, then drain in order.
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        push(5'd3, 5'd1, 5'd1);
        push(5'd4, 5'd1, 5'd1);
        check("two_in_ready", in_ready, 0);
        check("two_out_rd", out_rd, 3);
        in_valid = 1'b1; in_rd = 5'd9;
        step();
        in_valid = 1'b0;
        check("two_stall_rd", out_rd, 3);
        out_ready = 1'b1;
        step();
        check("drain_rd4", out_rd, 4);
        check("drain_valid", out_valid, 1);
        check("drain_in_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);

        // Simultaneous pop and push in ONE replaces main.
        push(5'd10, 5'd1, 5'd1);
        in_valid = 1'b1; in_rd = 5'd11; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("swap_rd", out_rd, 11);
        check("swap_valid", out_valid, 1);
        step();
        out_ready = 1'b0;
        check("swap_drained", out_valid, 0);

        // Flush in TWO with a pending input.
        push(5'd12, 5'd1, 5'd1);
        push(5'd13, 5'd1, 5'd1);
        in_valid = 1'b1; in_rd = 5'd14; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush2_valid", out_valid, 0);
        check("flush2_in_ready", in_ready, 1);
        step();
        check("flush2_stays_empty", out_valid, 0);

        // Flush in ONE discards an accepted input.
        push(5'd15, 5'd1, 5'd1);
        in_valid = 1'b1; in_rd = 5'd16; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        check("flush1_valid", out_valid, 0);

        // Reset while in TWO.
        rf_rdata1 = 32'h00001234;
        push(5'd20, 5'd1, 5'd1);
        push(5'd21, 5'd1, 5'd1);
        check("pre_rst_op1", out_op1, 32'h00001234);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        step();
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_op1", out_op1, 0);
        check("rel_valid", out_valid, 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
